// File: rtl/led_display_pkg.sv
// Shared mode codes and sequencer state type for the LED display blocks.
package led_display_pkg;

  localparam logic [3:0] GL_MODE_OFF    = 4'd0;
  localparam logic [3:0] GL_MODE_SOLID  = 4'd1;
  localparam logic [3:0] GL_MODE_SCAN_H = 4'd2;
  localparam logic [3:0] GL_MODE_SCAN_V = 4'd3;
  localparam logic [3:0] GL_MODE_PULSE  = 4'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PEND  = 2'd2,
    BLANK = 2'd3
  } seq_state_t;

  // Colour cycle skips 0 so a running panel is never dark.
  function automatic logic [2:0] next_colour(input logic [2:0] c);
    return (c == 3'd7) ? 3'd1 : c + 3'd1;
  endfunction

endpackage

// File: rtl/seq_dwell_timer.sv
// Saturating up-counter with synchronous clear and a terminal-count compare.
module seq_dwell_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] count;

  assign done = (count == limit);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && !done) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/led_display_mode_sequencer.sv
// Playlist controller feeding mode/colour to the LED pattern generator.
// Optional LED_SEQ_COLOUR_CYCLE_EN: colour steps 1..7 on each playlist wrap.
module led_display_mode_sequencer
  import led_display_pkg::*;
#(
  parameter int SYS_CLK_FREQ = 100_000_000,
  parameter int SIMULATION   = 0,
  parameter int DWELL_CYCLES = (SIMULATION != 0) ? 2000 : 2 * SYS_CLK_FREQ,
  parameter int BLANK_CYCLES = 16,
  parameter int PEND_TIMEOUT = 4096
) (
  input  logic       clk_in,
  input  logic       n_reset_in,
  input  logic       enable_in,
  input  logic       step_in,
  input  logic       pause_in,
  input  logic [2:0] colour_in,
  input  logic       row_valid_in,
  input  logic [3:0] row_address_in,
  output logic [3:0] mode_out,
  output logic [2:0] colour_out,
  output logic [1:0] step_out,
  output logic       switching_out
);

  localparam int DW = $clog2(DWELL_CYCLES + 1);
  localparam int PB_MAX =
    (PEND_TIMEOUT > BLANK_CYCLES) ? PEND_TIMEOUT : BLANK_CYCLES;
  localparam int PW = $clog2(PB_MAX + 1);

  localparam logic [DW-1:0] DWELL_LIM = DW'(DWELL_CYCLES - 1);
  localparam logic [PW-1:0] PEND_LIM  = PW'(PEND_TIMEOUT - 1);
  localparam logic [PW-1:0] BLANK_LIM = PW'(BLANK_CYCLES - 1);

  localparam logic [3:0] PLAYLIST [4] = '{
    GL_MODE_SOLID,
    GL_MODE_SCAN_H,
    GL_MODE_SCAN_V,
    GL_MODE_PULSE
  };

  seq_state_t    state;
  logic          frame_end;
  logic          dwell_clear;
  logic          dwell_en;
  logic          dwell_done;
  logic          pb_clear;
  logic          pb_en;
  logic          pb_done;
  logic [PW-1:0] pb_limit;
  logic [1:0]    next_step;
  logic          wrap_now;

  assign frame_end = row_valid_in && (row_address_in == 4'd15);
  assign next_step = step_out + 2'd1;
  assign wrap_now  = (state == BLANK) && pb_done && (step_out == 2'd3);

  assign dwell_clear = (state != RUN);
  assign dwell_en    = (state == RUN) && !pause_in;

  // One counter serves both PEND and BLANK; it restarts at each hand-over.
  assign pb_clear = (state == IDLE) || (state == RUN) ||
                    ((state == PEND) && (frame_end || pb_done));
  assign pb_en    = (state == PEND) || (state == BLANK);
  assign pb_limit = (state == BLANK) ? BLANK_LIM : PEND_LIM;

  seq_dwell_timer #(
    .W(DW)
  ) u_dwell (
    .clk  (clk_in),
    .rst_n(n_reset_in),
    .clear(dwell_clear),
    .en   (dwell_en),
    .limit(DWELL_LIM),
    .done (dwell_done)
  );

  seq_dwell_timer #(
    .W(PW)
  ) u_pend_blank (
    .clk  (clk_in),
    .rst_n(n_reset_in),
    .clear(pb_clear),
    .en   (pb_en),
    .limit(pb_limit),
    .done (pb_done)
  );

  always_ff @(posedge clk_in) begin
    if (!n_reset_in || !enable_in) begin
      state         <= IDLE;
      step_out      <= 2'd0;
      mode_out      <= GL_MODE_OFF;
      switching_out <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state         <= RUN;
          step_out      <= 2'd0;
          mode_out      <= PLAYLIST[0];
          switching_out <= 1'b0;
        end
        RUN: begin
          if (step_in || dwell_done) begin
            state         <= PEND;
            switching_out <= 1'b1;
          end
        end
        PEND: begin
          if (frame_end || pb_done) begin
            state    <= BLANK;
            mode_out <= GL_MODE_OFF;
          end
        end
        BLANK: begin
          if (pb_done) begin
            state         <= RUN;
            step_out      <= next_step;
            mode_out      <= PLAYLIST[next_step];
            switching_out <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LED_SEQ_COLOUR_CYCLE_EN
  logic [2:0] unused_colour;
  assign unused_colour = colour_in;

  always_ff @(posedge clk_in) begin
    if (!n_reset_in) begin
      colour_out <= 3'd0;
    end else if (enable_in && (state == IDLE)) begin
      colour_out <= 3'd1;
    end else if (enable_in && wrap_now) begin
      colour_out <= next_colour(colour_out);
    end
  end
`else
  logic unused_wrap;
  assign unused_wrap = wrap_now;

  always_ff @(posedge clk_in) begin
    if (!n_reset_in) begin
      colour_out <= 3'd0;
    end else begin
      colour_out <= colour_in;
    end
  end
`endif

endmodule

// File: tb/tb_led_display_mode_sequencer.sv
// Scoreboard bench for led_display_mode_sequencer (SIMULATION=1 timers).
`timescale 1ns/1ps
module tb_led_display_mode_sequencer;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       enable;
  logic       step;
  logic       pause;
  logic [2:0] colour_in;
  logic       row_valid;
  logic [3:0] row_addr;
  logic [3:0] mode_out;
  logic [2:0] colour_out;
  logic [1:0] step_out;
  logic       switching_out;

  typedef struct {
    int         at;
    string      name;
    logic [3:0] mode;
    logic [1:0] step;
    logic       sw;
    logic [2:0] col;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         n_pass = 0;
  int         n_total = 0;
  logic [2:0] ecol;
  logic [3:0] play [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  led_display_mode_sequencer #(
    .SIMULATION(1)
  ) dut (
    .clk_in        (clk),
    .n_reset_in    (n_reset),
    .enable_in     (enable),
    .step_in       (step),
    .pause_in      (pause),
    .colour_in     (colour_in),
    .row_valid_in  (row_valid),
    .row_address_in(row_addr),
    .mode_out      (mode_out),
    .colour_out    (colour_out),
    .step_out      (step_out),
    .switching_out (switching_out)
  );

  task automatic expect_at(input int at, input string nm,
                           input logic [3:0] m, input logic [1:0] s,
                           input logic sw);
    exp_t e;
    e.at = at; e.name = nm; e.mode = m;
    e.step = s; e.sw = sw; e.col = ecol;
    sb.push_back(e);
  endtask

  task automatic wait_until(input int at);
    while (cyc < at) @(negedge clk);
  endtask

  always @(posedge clk) begin
    #2;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at <= cyc) begin
        n_total++;
        if (sb[i].at == cyc && mode_out === sb[i].mode &&
            step_out === sb[i].step && switching_out === sb[i].sw &&
            colour_out === sb[i].col)
          n_pass++;
        else
          $display("FAIL %s cyc=%0d got mode=%0d step=%0d sw=%0b col=%0d want mode=%0d step=%0d sw=%0b col=%0d (due %0d)",
                   sb[i].name, cyc, mode_out, step_out, switching_out,
                   colour_out, sb[i].mode, sb[i].step, sb[i].sw,
                   sb[i].col, sb[i].at);
        sb.delete(i);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d pending=%0d", cyc, sb.size());
    $fatal(1);
  end

  initial begin
    int base, s, p, f, c, cur, nxt;
    play = '{4'd1, 4'd2, 4'd3, 4'd4};
    n_reset = 0; enable = 0; step = 0; pause = 0;
    colour_in = 0; row_valid = 0; row_addr = 0; ecol = 0;

    repeat (2) @(negedge clk);
    expect_at(cyc + 1, "reset_a", 4'd0, 2'd0, 1'b0);
    expect_at(cyc + 2, "reset_b", 4'd0, 2'd0, 1'b0);
    wait_until(4);
    n_reset = 1;
    expect_at(cyc + 1, "idle_disabled", 4'd0, 2'd0, 1'b0);
    @(negedge clk);
    enable = 1;
`ifdef LED_SEQ_COLOUR_CYCLE_EN
    ecol = 3'd1;
`endif
    expect_at(cyc + 1, "enter_run", 4'd1, 2'd0, 1'b0);
    @(negedge clk);
    base = cyc;

    expect_at(base + 1999, "dwell_hold", 4'd1, 2'd0, 1'b0);
    expect_at(base + 2000, "dwell_pend", 4'd1, 2'd0, 1'b1);
    wait_until(base + 2000);
    n_total++;
    if (switching_out === 1'b1 && mode_out === 4'd1)
      n_pass++;
    else
      $display("FAIL direct_pend sw=%0b mode=%0d",
               switching_out, mode_out);
    row_valid = 1; row_addr = 14;
    expect_at(cyc + 1, "pend_row14", 4'd1, 2'd0, 1'b1);
    @(negedge clk);
    row_valid = 0; row_addr = 15;
    expect_at(cyc + 1, "pend_novalid", 4'd1, 2'd0, 1'b1);
    @(negedge clk);
    row_valid = 1; row_addr = 15; f = cyc;
    expect_at(f + 1, "blank_start", 4'd0, 2'd0, 1'b1);
    expect_at(f + 16, "blank_end", 4'd0, 2'd0, 1'b1);
    expect_at(f + 17, "run_step1", 4'd2, 2'd1, 1'b0);
    @(negedge clk);
    row_valid = 0; row_addr = 0;
    wait_until(f + 17);
    base = cyc;

    wait_until(base + 10);
    step = 1; s = cyc;
    expect_at(s + 1, "step_pend", 4'd2, 2'd1, 1'b1);
    @(negedge clk);
    step = 0;
    wait_until(s + 5);
    step = 1;
    expect_at(s + 6, "pend_ign_step", 4'd2, 2'd1, 1'b1);
    expect_at(s + 40, "pend_hold", 4'd2, 2'd1, 1'b1);
    @(negedge clk);
    step = 0;
    wait_until(s + 40);
    row_valid = 1; row_addr = 15;
    expect_at(s + 41, "blank2_start", 4'd0, 2'd1, 1'b1);
    expect_at(s + 56, "blank2_end", 4'd0, 2'd1, 1'b1);
    expect_at(s + 57, "run_step2", 4'd3, 2'd2, 1'b0);
    @(negedge clk);
    row_valid = 0; row_addr = 0;
    wait_until(s + 45);
    step = 1;
    @(negedge clk);
    step = 0;
    wait_until(s + 57);
    base = cyc;

    wait_until(base + 5);
    step = 1; p = cyc + 1;
    expect_at(p, "pend3", 4'd3, 2'd2, 1'b1);
    expect_at(p + 4095, "pend_last", 4'd3, 2'd2, 1'b1);
    expect_at(p + 4096, "forced_blank", 4'd0, 2'd2, 1'b1);
    expect_at(p + 4112, "run_step3", 4'd4, 2'd3, 1'b0);
    @(negedge clk);
    step = 0; row_valid = 1; row_addr = 14;
    wait_until(p + 4096);
    n_total++;
    if (mode_out === 4'd0 && switching_out === 1'b1)
      n_pass++;
    else
      $display("FAIL direct_forced mode=%0d sw=%0b",
               mode_out, switching_out);
    row_valid = 0; row_addr = 0;
    wait_until(p + 4112);
    base = cyc;

    wait_until(base + 100);
    pause = 1;
    expect_at(base + 5100, "paused", 4'd4, 2'd3, 1'b0);
    wait_until(base + 5100);
    pause = 0;
    expect_at(base + 6999, "resume_hold", 4'd4, 2'd3, 1'b0);
    expect_at(base + 7000, "resume_pend", 4'd4, 2'd3, 1'b1);
    wait_until(base + 7000);

    row_valid = 1; row_addr = 15; f = cyc;
    expect_at(f + 1, "wrap_blank", 4'd0, 2'd3, 1'b1);
`ifdef LED_SEQ_COLOUR_CYCLE_EN
    ecol = (ecol == 3'd7) ? 3'd1 : ecol + 3'd1;
`endif
    expect_at(f + 17, "wrap_run", 4'd1, 2'd0, 1'b0);
    @(negedge clk);
    row_valid = 0; row_addr = 0;
    wait_until(f + 17);
    n_total++;
    if (mode_out === 4'd1 && step_out === 2'd0)
      n_pass++;
    else
      $display("FAIL direct_wrap mode=%0d step=%0d",
               mode_out, step_out);

    colour_in = 3'd5;
`ifndef LED_SEQ_COLOUR_CYCLE_EN
    ecol = 3'd5;
`endif
    expect_at(cyc + 1, "colour_a", 4'd1, 2'd0, 1'b0);
    @(negedge clk);
    colour_in = 3'd2;
`ifndef LED_SEQ_COLOUR_CYCLE_EN
    ecol = 3'd2;
`endif
    expect_at(cyc + 1, "colour_b", 4'd1, 2'd0, 1'b0);

    cur = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      step = 1; c = cyc;
      expect_at(c + 1, "fast_pend", play[cur], 2'(cur), 1'b1);
      @(negedge clk);
      step = 0; row_valid = 1; row_addr = 15;
      expect_at(c + 2, "fast_blank", 4'd0, 2'(cur), 1'b1);
      @(negedge clk);
      row_valid = 0; row_addr = 0;
      nxt = (cur + 1) % 4;
`ifdef LED_SEQ_COLOUR_CYCLE_EN
      if (cur == 3) ecol = (ecol == 3'd7) ? 3'd1 : ecol + 3'd1;
`endif
      expect_at(c + 18, "fast_run", play[nxt], 2'(nxt), 1'b0);
      wait_until(c + 18);
      cur = nxt;
    end

    @(negedge clk);
    step = 1; c = cyc;
    expect_at(c + 1, "d_pend", play[cur], 2'(cur), 1'b1);
    @(negedge clk);
    step = 0; row_valid = 1; row_addr = 15;
    expect_at(c + 2, "d_blank", 4'd0, 2'(cur), 1'b1);
    expect_at(c + 6, "d_blank_hold", 4'd0, 2'(cur), 1'b1);
    @(negedge clk);
    row_valid = 0; row_addr = 0;
    wait_until(c + 6);
    enable = 0;
    expect_at(c + 7, "disable_blank", 4'd0, 2'd0, 1'b0);
    expect_at(c + 8, "disabled_idle", 4'd0, 2'd0, 1'b0);
    wait_until(c + 8);
    n_total++;
    if (mode_out === 4'd0 && step_out === 2'd0 &&
        switching_out === 1'b0)
      n_pass++;
    else
      $display("FAIL direct_disable mode=%0d step=%0d sw=%0b",
               mode_out, step_out, switching_out);
    enable = 1;
`ifdef LED_SEQ_COLOUR_CYCLE_EN
    ecol = 3'd1;
`endif
    expect_at(c + 9, "reenable", 4'd1, 2'd0, 1'b0);
    expect_at(c + 19, "run_pre_reset", 4'd1, 2'd0, 1'b0);
    wait_until(c + 19);
    n_reset = 0;
    ecol = 3'd0;
    expect_at(c + 20, "reset_in_run", 4'd0, 2'd0, 1'b0);
    wait_until(c + 20);
    n_reset = 1;
`ifdef LED_SEQ_COLOUR_CYCLE_EN
    ecol = 3'd1;
`else
    ecol = 3'd2;
`endif
    expect_at(c + 21, "run_after_reset", 4'd1, 2'd0, 1'b0);
    wait_until(c + 25);

    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_total++;
      $display("FAIL %s never sampled (due cycle %0d, now %0d)",
               e.name, e.at, cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
